dma_desc_queue: RTL and testbench

//  Memory-mapped descriptor queue sitting directly upstream of the DMA controller.
//  The core programs SRC/DST/LEN over the data bus and pushes descriptors into a small FIFO.

---
 rtl/dma_desc_queue.sv | 105 ++++++++++
 tb/tb_dma_desc_queue.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dma_desc_queue.sv
// dma_desc_queue: memory-mapped DMA descriptor FIFO with a valid/ready head, a completion counter and a level IRQ.
module dma_desc_queue #(
  parameter logic [31:0] BASE_ADDR = 32'h000F_0100,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFE0,
  parameter int          DEPTH     = 4,
  parameter int          LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_req,
  input  logic             bus_we,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ack,
  output logic             desc_valid,
  input  logic             desc_ready,
  output logic [31:0]      desc_src,
  output logic [31:0]      desc_dst,
  output logic [LEN_W-1:0] desc_len,
  input  logic             dma_done,
  output logic             irq
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]      src_q, dst_q, rdata_q, rd_val;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      mem_src_q [DEPTH];
  logic [31:0]      mem_dst_q [DEPTH];
  logic [LEN_W-1:0] mem_len_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d, wr_idx;
  logic [AW:0]      cnt_q, cnt_d;
  logic [7:0]       done_q, done_d;
  logic             err_q, err_d, irq_en_q, irq_q, ack_q;
  logic             accept, wr, wr_ctrl, wr_stat, empty, full, pop, flush, push_req, push_ok;
  logic [4:0]       off;
  // Holding off while ack is high keeps a long request from being taken twice.
  assign accept   = bus_req & !ack_q & ((bus_addr & ADDR_MASK) == BASE_ADDR);
  assign off      = bus_addr[4:0];
  assign wr       = accept & bus_we;
  assign wr_ctrl  = wr & (off == 5'h0C);
  assign wr_stat  = wr & (off == 5'h10);
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == (AW+1)'(DEPTH);
  assign pop      = !empty & desc_ready;
  assign flush    = wr_ctrl & bus_wdata[1];
  assign push_req = wr_ctrl & bus_wdata[0];
  // A full FIFO still takes a push when the head leaves in the same cycle; flush always makes room.
  assign push_ok  = push_req & (len_q != '0) & (flush | !full | pop);
  assign wr_idx   = flush ? '0 : wp_q;
  always_comb begin
    rp_d   = flush ? '0 : rp_q + AW'(pop);
    wp_d   = wr_idx + AW'(push_ok);
    cnt_d  = flush ? (AW+1)'(push_ok) : cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    done_d = (wr_stat & bus_wdata[8]) ? {7'b0, dma_done} : done_q + 8'(dma_done & (done_q != 8'hFF));
    err_d  = (push_req & !push_ok) | (err_q & !(wr_stat & bus_wdata[16]));
    rd_val = off == 5'h00 ? src_q :
             off == 5'h04 ? dst_q :
             off == 5'h08 ? 32'(len_q) :
             off == 5'h0C ? {23'b0, irq_en_q, 8'b0} :
             off == 5'h10 ? {15'b0, err_q, done_q, 2'b0, empty, full, 4'(cnt_q)} : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q   <= accept;
      rdata_q <= (accept & !bus_we) ? rd_val : '0;
      if (wr && off == 5'h00) src_q <= bus_wdata;
      if (wr && off == 5'h04) dst_q <= bus_wdata;
      if (wr && off == 5'h08) len_q <= bus_wdata[LEN_W-1:0];
      if (wr_ctrl) irq_en_q <= bus_wdata[8];
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
      irq_q  <= irq_en_q & ((done_q != '0) | err_q);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_src_q[wr_idx] <= src_q;
      mem_dst_q[wr_idx] <= dst_q;
      mem_len_q[wr_idx] <= len_q;
    end
  end
  assign bus_ack    = ack_q;
  assign bus_rdata  = rdata_q;
  assign desc_valid = !empty;
  assign desc_src   = empty ? '0 : mem_src_q[rp_q];
  assign desc_dst   = empty ? '0 : mem_dst_q[rp_q];
  assign desc_len   = empty ? '0 : mem_len_q[rp_q];
  assign irq        = irq_q;
endmodule

// File: tb/tb_dma_desc_queue.sv
// tb_dma_desc_queue: directed bench for dma_desc_queue; a descriptor scoreboard is checked at every head handshake.
module tb_dma_desc_queue;
  localparam logic [31:0] B = 32'h000F_0100;
  logic        clk = 1'b0, rst = 1'b0, bus_req = 1'b0, bus_we = 1'b0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic        desc_ready = 1'b0, dma_done = 1'b0;
  logic [31:0] bus_rdata, desc_src, desc_dst;
  logic [15:0] desc_len;
  logic        bus_ack, desc_valid, irq;
  typedef struct packed {logic [31:0] s; logic [31:0] d; logic [15:0] l;} desc_t;
  desc_t sb[$];
  int checks = 0, failures = 0;

  dma_desc_queue dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_src(desc_src),
    .desc_dst(desc_dst), .desc_len(desc_len), .dma_done(dma_done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(logic [7:0] off, logic [31:0] d);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = B + 32'(off); bus_wdata = d;
    @(negedge clk);
    chk("wr_ack", 32'(bus_ack), 32'd1);
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  task automatic rd(logic [7:0] off, logic [31:0] exp, string tag);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = B + 32'(off);
    @(negedge clk);
    chk("rd_ack", 32'(bus_ack), 32'd1);
    chk(tag, bus_rdata, exp);
    bus_req = 1'b0;
  endtask

  task automatic push(logic [31:0] s, logic [31:0] d, logic [15:0] l);
    wr(8'h00, s); wr(8'h04, d); wr(8'h08, 32'(l)); wr(8'h0C, 32'h1);
    sb.push_back('{s: s, d: d, l: l});
  endtask

  task automatic check_head(string tag);
    chk({tag, "_valid"}, 32'(desc_valid), 32'd1);
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s_sb observed=empty_scoreboard expected=entry", tag);
    end else begin
      chk({tag, "_src"}, desc_src, sb[0].s);
      chk({tag, "_dst"}, desc_dst, sb[0].d);
      chk({tag, "_len"}, 32'(desc_len), 32'(sb[0].l));
    end
  endtask

  task automatic pop_one(string tag);
    check_head(tag);
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
    if (sb.size() != 0) sb.delete(0);
  endtask

  task automatic pulse();
    @(negedge clk); dma_done = 1'b1;
    @(negedge clk); dma_done = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(desc_valid), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_ack", 32'(bus_ack), 0);
    chk("rst_rdata", bus_rdata, 0);
    rst = 1'b1;
    rd(8'h10, 32'h20, "st_reset");
    rd(8'h00, 32'h0, "src_reset");
    @(negedge clk); bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'h000F_0200;
    @(negedge clk); chk("miss_no_ack", 32'(bus_ack), 0); bus_req = 1'b0;
    rd(8'h14, 32'h0, "rd_unmapped");
    // single push
    push(32'h100, 32'h200, 16'd8);
    check_head("t1_head");
    rd(8'h10, 32'h1, "t1_status");
    @(negedge clk); chk("rdata_idle_zero", bus_rdata, 0);
    // overfill then drain in order
    for (int i = 1; i < 4; i++) push(32'h1000 + 32'(i), 32'h2000 + 32'(i), 16'(i + 1));
    wr(8'h0C, 32'h1);
    rd(8'h10, 32'h0001_0014, "t2_full_err");
    for (int i = 0; i < 4; i++) pop_one("t2_pop");
    chk("t2_drained", 32'(desc_valid), 0);
    rd(8'h10, 32'h0001_0020, "t2_empty_err");
    wr(8'h10, 32'h0001_0000);
    rd(8'h10, 32'h20, "t2_err_clr");
    // push and pop together while full
    for (int i = 0; i < 4; i++) push(32'h3000 + 32'(i), 32'h3100 + 32'(i), 16'(i + 10));
    wr(8'h00, 32'h3AAA); wr(8'h04, 32'h4AAA); wr(8'h08, 32'd9);
    @(negedge clk);
    check_head("t3_head");
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = B + 32'h0C; bus_wdata = 32'h1; desc_ready = 1'b1;
    @(negedge clk);
    chk("t3_ack", 32'(bus_ack), 1);
    bus_req = 1'b0; bus_we = 1'b0; desc_ready = 1'b0;
    sb.delete(0);
    sb.push_back('{s: 32'h3AAA, d: 32'h4AAA, l: 16'd9});
    rd(8'h10, 32'h14, "t3_level_full");
    for (int i = 0; i < 4; i++) pop_one("t3_pop");
    // zero length, flush, flush with push
    wr(8'h08, 32'h0); wr(8'h0C, 32'h1);
    rd(8'h10, 32'h0001_0020, "t4_len0_err");
    chk("t4_len0_valid", 32'(desc_valid), 0);
    wr(8'h10, 32'h0001_0000);
    for (int i = 0; i < 3; i++) push(32'h5000 + 32'(i), 32'h6000 + 32'(i), 16'd5);
    wr(8'h0C, 32'h2);
    chk("t4_flush_valid", 32'(desc_valid), 0);
    rd(8'h10, 32'h20, "t4_flush_status");
    sb.delete();
    for (int i = 0; i < 2; i++) push(32'h7000 + 32'(i), 32'h8000 + 32'(i), 16'd7);
    wr(8'h0C, 32'h3);
    sb.delete();
    sb.push_back('{s: 32'h7001, d: 32'h8001, l: 16'd7});
    rd(8'h10, 32'h1, "t4_flush_push");
    pop_one("t4_pop");
    // completion counter and irq
    wr(8'h0C, 32'h100);
    chk("t5_irq_off", 32'(irq), 0);
    pulse();
    chk("t5_irq_lag", 32'(irq), 0);
    @(negedge clk); chk("t5_irq_on", 32'(irq), 1);
    pulse(); pulse();
    rd(8'h10, 32'h0320, "t5_cnt3");
    wr(8'h10, 32'h100);
    @(negedge clk); chk("t5_irq_clr", 32'(irq), 0);
    @(negedge clk); dma_done = 1'b1;
    repeat (300) @(negedge clk);
    dma_done = 1'b0;
    rd(8'h10, 32'hFF20, "t5_saturate");
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = B + 32'h10; bus_wdata = 32'h100; dma_done = 1'b1;
    @(negedge clk);
    chk("t5_incclr_ack", 32'(bus_ack), 1);
    bus_req = 1'b0; bus_we = 1'b0; dma_done = 1'b0;
    rd(8'h10, 32'h0120, "t5_inc_clr");
    // asynchronous reset mid-queue
    wr(8'h00, 32'hA0); wr(8'h04, 32'hB0); wr(8'h08, 32'd3); wr(8'h0C, 32'h101);
    @(negedge clk);
    chk("t6_irq_pre", 32'(irq), 1);
    chk("t6_valid_pre", 32'(desc_valid), 1);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = B;
    @(negedge clk);
    chk("t6_ack_pre", 32'(bus_ack), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_ack_async", 32'(bus_ack), 0);
    chk("t6_valid_async", 32'(desc_valid), 0);
    chk("t6_irq_async", 32'(irq), 0);
    chk("t6_src_async", desc_src, 0);
    bus_req = 1'b0;
    #3 rst = 1'b1;
    sb.delete();
    rd(8'h00, 32'h0, "t6_src_reg");
    rd(8'h08, 32'h0, "t6_len_reg");
    rd(8'h10, 32'h20, "t6_status");
    chk("t6_irq_after", 32'(irq), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
